// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// the per-stage tracking record and the small matching helpers.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_GRF   = 2'd0;
  localparam logic [1:0] FWD_M     = 2'd1;
  localparam logic [1:0] FWD_E     = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '{1'b0, 5'd0, 2'd0};

  // Tnew counts down as the producer moves one stage older, never below zero.
  function automatic logic [1:0] tnew_step(input logic [1:0] tnew);
    if (tnew == 2'd0) begin
      tnew_step = 2'd0;
    end else begin
      tnew_step = tnew - 2'd1;
    end
  endfunction

  function automatic logic stage_match(input stage_t st, input logic [4:0] src);
    stage_match = st.valid && (st.dst == src) && (src != 5'd0);
  endfunction

  function automatic logic src_stall(input stage_t e, input stage_t m,
                                     input logic [4:0] src, input logic [1:0] tuse);
    if (tuse == TUSE_NONE) begin
      src_stall = 1'b0;
    end else begin
      src_stall = (stage_match(e, src) && (e.tnew > tuse)) ||
                  (stage_match(m, src) && (m.tnew > tuse));
    end
  endfunction

  // The youngest matching stage decides; it is selected once its result will
  // exist by the time the operand is consumed, otherwise the GRF path is kept.
  function automatic logic [1:0] fwd_pick(input stage_t e, input stage_t m,
                                          input logic [4:0] src, input logic [1:0] tuse);
    if (stage_match(e, src)) begin
      if (e.tnew <= tuse) begin
        fwd_pick = FWD_E;
      end else begin
        fwd_pick = FWD_GRF;
      end
    end else if (stage_match(m, src)) begin
      if (m.tnew <= tuse) begin
        fwd_pick = FWD_M;
      end else begin
        fwd_pick = FWD_GRF;
      end
    end else begin
      fwd_pick = FWD_GRF;
    end
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Multiply/divide busy-time counter: loads a cycle count, then counts down to 0.
module md_busy_ctr
  import hazard_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] count;

  // Reset beats load, load beats countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end else begin
      count <= '0;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for a 5-stage pipeline with an iterative
// multiply/divide unit; outputs are combinational from E/M state and D inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] D_dst,
  input  logic [1:0] D_tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel
);

  localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  stage_t     e_stage;
  stage_t     m_stage;
  stage_t     w_stage;
  logic       data_stall;
  logic       md_busy;
  logic       md_load;
  logic [CNT_W-1:0] md_load_val;
  logic       unused_w;

  // Pipeline tracker: a stall turns E into a bubble while M and W keep draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_stage <= STAGE_EMPTY;
      m_stage <= STAGE_EMPTY;
      w_stage <= STAGE_EMPTY;
    end else begin
      if (stall) begin
        e_stage <= STAGE_EMPTY;
      end else begin
        e_stage <= '{1'b1, D_dst, D_tnew};
      end
      m_stage <= '{e_stage.valid, e_stage.dst, tnew_step(e_stage.tnew)};
      w_stage <= '{m_stage.valid, m_stage.dst, tnew_step(m_stage.tnew)};
    end
  end

  // W is tracked for completeness; its bypass is covered by the GRF read path.
  assign unused_w = ^w_stage;

  // Hazard detection and forward selection for both D sources.
  always_comb begin
    data_stall = src_stall(e_stage, m_stage, D_rs, D_tuse_rs) |
                 src_stall(e_stage, m_stage, D_rt, D_tuse_rt);
    fwd_rs_sel = fwd_pick(e_stage, m_stage, D_rs, D_tuse_rs);
    fwd_rt_sel = fwd_pick(e_stage, m_stage, D_rt, D_tuse_rt);
    stall      = data_stall | (D_md_use & md_busy);
  end

  // A start held in D by a stall is only taken on the edge that issues it.
  always_comb begin
    md_load = D_md_start & ~stall;
    if (D_md_div) begin
      md_load_val = CNT_W'(DIV_CYCLES);
    end else begin
      md_load_val = CNT_W'(MULT_CYCLES);
    end
  end

  md_busy_ctr #(
    .W(CNT_W)
  ) u_md_busy_ctr (
    .clk     (clk),
    .reset   (reset),
    .load    (md_load),
    .load_val(md_load_val),
    .busy    (md_busy)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default MULT_CYCLES=5, DIV_CYCLES=10).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_dst;
  logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
  logic       D_md_start, D_md_div, D_md_use;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int total = 0;
  int bad   = 0;

  hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .D_rs      (D_rs),
    .D_rt      (D_rt),
    .D_tuse_rs (D_tuse_rs),
    .D_tuse_rt (D_tuse_rt),
    .D_dst     (D_dst),
    .D_tnew    (D_tnew),
    .D_md_start(D_md_start),
    .D_md_div  (D_md_div),
    .D_md_use  (D_md_use),
    .stall     (stall),
    .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt,
                       input logic [4:0] dst, input logic [1:0] tnew);
    D_rs = rs; D_tuse_rs = trs; D_rt = rt; D_tuse_rt = trt;
    D_dst = dst; D_tnew = tnew;
    D_md_start = 1'b0; D_md_div = 1'b0; D_md_use = 1'b0;
    #1;
  endtask

  task automatic drive_md(input logic start, input logic div, input logic use_md);
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    D_md_start = start; D_md_div = div; D_md_use = use_md;
    #1;
  endtask

  task automatic count_stall(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (stall !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    tick(); tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
    total++; if (fwd_rs_sel !== 2'd0) begin bad++; $display("FAIL reset_rs_sel: got %0d want 0", fwd_rs_sel); end
    total++; if (fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL reset_rt_sel: got %0d want 0", fwd_rt_sel); end
    reset = 1'b0;
    tick();
    total++; if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'd0) begin bad++;
      $display("FAIL post_reset_idle: got %b want 00000", {stall, fwd_rs_sel, fwd_rt_sel}); end
  endtask

  task automatic test_load_use;
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2);
    tick();
    drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_use_stall1: got %0b want 1", stall); end
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_use_stall2: got %0b want 0", stall); end
    total++; if (fwd_rs_sel !== 2'd1) begin bad++; $display("FAIL load_use_fwd: got %0d want 1", fwd_rs_sel); end
    tick();
  endtask

  task automatic test_alu_b2b;
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd1);
    tick();
    drive(5'd0, 2'd3, 5'd9, 2'd1, 5'd0, 2'd0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %0b want 0", stall); end
    total++; if (fwd_rt_sel !== 2'd2) begin bad++; $display("FAIL alu_rt_fwd: got %0d want 2", fwd_rt_sel); end
    total++; if (fwd_rs_sel !== 2'd0) begin bad++; $display("FAIL alu_rs_fwd: got %0d want 0", fwd_rs_sel); end
    tick();
  endtask

  task automatic test_reg0;
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2);
    tick();
    drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reg0_stall: got %0b want 0", stall); end
    total++; if (fwd_rs_sel !== 2'd0) begin bad++; $display("FAIL reg0_fwd: got %0d want 0", fwd_rs_sel); end
    tick();
  endtask

  task automatic test_priority;
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd0);
    tick(); tick();
    drive(5'd5, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0);
    total++; if (fwd_rs_sel !== 2'd2) begin bad++; $display("FAIL prio_rs: got %0d want 2", fwd_rs_sel); end
    total++; if (fwd_rt_sel !== 2'd2) begin bad++; $display("FAIL prio_rt: got %0d want 2", fwd_rt_sel); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL prio_stall: got %0b want 0", stall); end
    tick();
    total++; if (fwd_rs_sel !== 2'd1) begin bad++; $display("FAIL m_only_fwd: got %0d want 1", fwd_rs_sel); end
    tick();
  endtask

  task automatic test_tuse_m_stall;
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd3);
    tick();
    drive(5'd7, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL tuse_none: got %0b want 0", stall); end
    drive(5'd7, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL e_tnew3_stall: got %0b want 1", stall); end
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    tick();
    drive(5'd0, 2'd3, 5'd7, 2'd1, 5'd0, 2'd0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL m_tnew2_stall: got %0b want 1", stall); end
    drive(5'd0, 2'd3, 5'd7, 2'd2, 5'd0, 2'd0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL m_tnew2_nostall: got %0b want 0", stall); end
    total++; if (fwd_rt_sel !== 2'd1) begin bad++; $display("FAIL m_tnew2_fwd: got %0d want 1", fwd_rt_sel); end
    tick();
  endtask

  task automatic test_md;
    int n;
    drive_md(1'b1, 1'b1, 1'b1);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL div_issue_stall: got %0b want 0", stall); end
    tick();
    drive_md(1'b0, 1'b0, 1'b1);
    count_stall(n);
    total++; if (n != 10) begin bad++; $display("FAIL div_busy: got %0d cycles want 10", n); end
    tick();
    drive_md(1'b1, 1'b0, 1'b1);
    tick();
    drive_md(1'b0, 1'b0, 1'b1);
    count_stall(n);
    total++; if (n != 5) begin bad++; $display("FAIL mult_busy: got %0d cycles want 5", n); end
    tick();
  endtask

  task automatic test_back_to_back_md;
    int n;
    drive_md(1'b1, 1'b0, 1'b1);
    tick();
    drive_md(1'b1, 1'b1, 1'b1);
    count_stall(n);
    total++; if (n != 5) begin bad++; $display("FAIL held_start_wait: got %0d cycles want 5", n); end
    tick();
    drive_md(1'b0, 1'b0, 1'b1);
    count_stall(n);
    total++; if (n != 10) begin bad++; $display("FAIL held_div_busy: got %0d cycles want 10", n); end
    tick();
  endtask

  task automatic test_reset_mid_op;
    drive_md(1'b1, 1'b1, 1'b1);
    tick();
    drive_md(1'b0, 1'b0, 1'b1);
    tick(); tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_div_stall: got %0b want 1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'd0) begin bad++;
      $display("FAIL reset_mid_div: got %b want 00000", {stall, fwd_rs_sel, fwd_rt_sel}); end
    tick(); tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL md_cleared: got %0b want 0", stall); end
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2);
    tick();
    drive(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL pre_reset_hazard: got %0b want 1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_clears_hazard: got %0b want 0", stall); end
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_b2b();
    test_reg0();
    test_priority();
    test_tuse_m_stall();
    test_md();
    test_back_to_back_md();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
